// File: rtl/modexp_io_port_if.sv
// modexp_io_port_if: host/core signal bundle for the ModExp word-serial I/O port.
// Rev 1.0 -- initial release. Optional load_cksum under MODEXP_IO_CKSUM_EN.
`default_nettype none

interface modexp_io_port_if #(
  parameter int DATA_WIDTH = 64,
  parameter int AW         = 6
);
  logic                  start_input;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] m_in;
  logic [DATA_WIDTH-1:0] e_in;
  logic [DATA_WIDTH-1:0] n_in;
  logic [DATA_WIDTH-1:0] r_in;
  logic [DATA_WIDTH-1:0] t_in;
  logic [63:0]           nprime0_in;
  logic                  op_we;
  logic [AW-1:0]         op_addr;
  logic [DATA_WIDTH-1:0] op_m;
  logic [DATA_WIDTH-1:0] op_e;
  logic [DATA_WIDTH-1:0] op_n;
  logic [DATA_WIDTH-1:0] op_r;
  logic [DATA_WIDTH-1:0] op_t;
  logic [63:0]           nprime0;
  logic                  load_done;
  logic                  start_compute;
  logic                  core_start;
  logic                  core_done;
  logic                  get_result;
  logic                  res_rd_en;
  logic [AW-1:0]         res_rd_addr;
  logic [DATA_WIDTH-1:0] res_rd_data;
  logic [DATA_WIDTH-1:0] res_out;
  logic                  res_valid;
  logic                  res_last;
  logic                  busy;
  logic [2:0]            state;
  logic                  err_proto;
`ifdef MODEXP_IO_CKSUM_EN
  logic [DATA_WIDTH-1:0] load_cksum;
`endif

  modport slave (
`ifdef MODEXP_IO_CKSUM_EN
    output load_cksum,
`endif
    input  start_input, in_valid, m_in, e_in, n_in, r_in, t_in, nprime0_in,
    input  start_compute, core_done, get_result, res_rd_data,
    output op_we, op_addr, op_m, op_e, op_n, op_r, op_t, nprime0, load_done,
    output core_start, res_rd_en, res_rd_addr, res_out, res_valid, res_last,
    output busy, state, err_proto
  );

  modport master (
`ifdef MODEXP_IO_CKSUM_EN
    input  load_cksum,
`endif
    output start_input, in_valid, m_in, e_in, n_in, r_in, t_in, nprime0_in,
    output start_compute, core_done, get_result, res_rd_data,
    input  op_we, op_addr, op_m, op_e, op_n, op_r, op_t, nprime0, load_done,
    input  core_start, res_rd_en, res_rd_addr, res_out, res_valid, res_last,
    input  busy, state, err_proto
  );
endinterface

`default_nettype wire

// File: rtl/modexp_io_port.sv
// modexp_io_port: word-serial operand loader / result unloader for the ModExp core.
// Rev 1.0 -- initial release. Define MODEXP_IO_CKSUM_EN to add the load_cksum output.
`default_nettype none

module modexp_io_port #(
  parameter int DATA_WIDTH = 64,
  parameter int WORDS      = 64,
  parameter int AW         = 6
) (
  input  wire logic       clk,
  input  wire logic       reset,
  modexp_io_port_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_LOADED  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_READY   = 3'd4;
  localparam logic [2:0] S_UNLOAD  = 3'd5;

  localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic                  op_we_q, op_we_d;
  logic [AW-1:0]         op_addr_q, op_addr_d;
  logic [DATA_WIDTH-1:0] op_m_q, op_m_d, op_e_q, op_e_d, op_n_q, op_n_d;
  logic [DATA_WIDTH-1:0] op_r_q, op_r_d, op_t_q, op_t_d;
  logic [63:0]           nprime0_q, nprime0_d;
  logic                  load_done_q, load_done_d;
  logic                  core_start_q, core_start_d;
  logic                  res_rd_en_q, res_rd_en_d;
  logic [AW-1:0]         res_rd_addr_q, res_rd_addr_d;
  logic                  rd_dly_q, rd_dly_d;
  logic                  rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] res_out_q, res_out_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_last_q, res_last_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic start_ok, wr_ok, err_ev;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an accepted start_input overrides every other request
  always_comb begin
    start_ok = bus.start_input &&
               (state_q inside {S_IDLE, S_LOADED, S_READY});
    wr_ok    = bus.in_valid && (state_q == S_LOAD) && !load_done_q;
    state_d  = state_q;
    if (start_ok) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:    if (load_done_q)       state_d = S_LOADED;
        S_LOADED:  if (bus.start_compute) state_d = S_COMPUTE;
        S_COMPUTE: if (bus.core_done)     state_d = S_READY;
        S_READY:   if (bus.get_result)    state_d = S_UNLOAD;
        S_UNLOAD:  if (res_last_q)        state_d = S_IDLE;
        default:                          state_d = state_q;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    err_ev = (bus.in_valid && !wr_ok && !start_ok) ||
             (bus.start_input && !start_ok) ||
             (bus.start_compute && state_q != S_LOADED) ||
             (bus.get_result && state_q != S_READY) ||
             (bus.core_done && state_q != S_COMPUTE);

    cnt_d         = cnt_q;
    op_we_d       = 1'b0;
    op_addr_d     = op_addr_q;
    op_m_d        = op_m_q;
    op_e_d        = op_e_q;
    op_n_d        = op_n_q;
    op_r_d        = op_r_q;
    op_t_d        = op_t_q;
    nprime0_d     = nprime0_q;
    load_done_d   = 1'b0;
    core_start_d  = 1'b0;
    res_rd_en_d   = 1'b0;
    res_rd_addr_d = res_rd_addr_q;
    // Read data arrives one cycle after the strobe, then lands in res_out
    rd_dly_d      = res_rd_en_q;
    rd_last_d     = res_rd_en_q && (res_rd_addr_q == LAST_ADDR);
    res_out_d     = rd_dly_q ? bus.res_rd_data : res_out_q;
    res_valid_d   = rd_dly_q;
    res_last_d    = rd_last_q;
    busy_d        = state_d inside {S_LOAD, S_COMPUTE, S_UNLOAD};
    err_d         = err_q || err_ev;

    if (start_ok) begin
      cnt_d     = '0;
      nprime0_d = bus.nprime0_in;
    end else if (wr_ok) begin
      op_we_d   = 1'b1;
      op_addr_d = cnt_q;
      op_m_d    = bus.m_in;
      op_e_d    = bus.e_in;
      op_n_d    = bus.n_in;
      op_r_d    = bus.r_in;
      op_t_d    = bus.t_in;
      if (cnt_q == LAST_ADDR) begin
        load_done_d = 1'b1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!start_ok && state_q == S_LOADED && bus.start_compute)
      core_start_d = 1'b1;

    if (!start_ok && state_q == S_READY && bus.get_result) begin
      res_rd_en_d   = 1'b1;
      res_rd_addr_d = '0;
    end else if (state_q == S_UNLOAD && res_rd_en_q && res_rd_addr_q != LAST_ADDR) begin
      res_rd_en_d   = 1'b1;
      res_rd_addr_d = res_rd_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      op_we_q       <= 1'b0;
      op_addr_q     <= '0;
      op_m_q        <= '0;
      op_e_q        <= '0;
      op_n_q        <= '0;
      op_r_q        <= '0;
      op_t_q        <= '0;
      nprime0_q     <= '0;
      load_done_q   <= 1'b0;
      core_start_q  <= 1'b0;
      res_rd_en_q   <= 1'b0;
      res_rd_addr_q <= '0;
      rd_dly_q      <= 1'b0;
      rd_last_q     <= 1'b0;
      res_out_q     <= '0;
      res_valid_q   <= 1'b0;
      res_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      op_we_q       <= op_we_d;
      op_addr_q     <= op_addr_d;
      op_m_q        <= op_m_d;
      op_e_q        <= op_e_d;
      op_n_q        <= op_n_d;
      op_r_q        <= op_r_d;
      op_t_q        <= op_t_d;
      nprime0_q     <= nprime0_d;
      load_done_q   <= load_done_d;
      core_start_q  <= core_start_d;
      res_rd_en_q   <= res_rd_en_d;
      res_rd_addr_q <= res_rd_addr_d;
      rd_dly_q      <= rd_dly_d;
      rd_last_q     <= rd_last_d;
      res_out_q     <= res_out_d;
      res_valid_q   <= res_valid_d;
      res_last_q    <= res_last_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

`ifdef MODEXP_IO_CKSUM_EN
  logic [DATA_WIDTH-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_ok)   cksum_d = '0;
    else if (wr_ok) cksum_d = cksum_q ^ bus.m_in ^ bus.e_in ^ bus.n_in ^ bus.r_in ^ bus.t_in;
  end

  always_ff @(posedge clk) begin
    if (reset) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign bus.load_cksum = cksum_q;
`endif

  assign bus.op_we       = op_we_q;
  assign bus.op_addr     = op_addr_q;
  assign bus.op_m        = op_m_q;
  assign bus.op_e        = op_e_q;
  assign bus.op_n        = op_n_q;
  assign bus.op_r        = op_r_q;
  assign bus.op_t        = op_t_q;
  assign bus.nprime0     = nprime0_q;
  assign bus.load_done   = load_done_q;
  assign bus.core_start  = core_start_q;
  assign bus.res_rd_en   = res_rd_en_q;
  assign bus.res_rd_addr = res_rd_addr_q;
  assign bus.res_out     = res_out_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_last    = res_last_q;
  assign bus.busy        = busy_q;
  assign bus.state       = state_q;
  assign bus.err_proto   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_modexp_io_port.sv
// tb_modexp_io_port: randomized scoreboard bench for modexp_io_port.
// Rev 1.0 -- initial release.
`default_nettype none

module tb_modexp_io_port;
  localparam int DW    = 64;
  localparam int WORDS = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modexp_io_port_if #(.DATA_WIDTH(DW), .AW(AW)) bus ();

  modexp_io_port #(.DATA_WIDTH(DW), .WORDS(WORDS), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] m, e, n, r, t;
    bit            ld;
  } wr_t;

  typedef struct {
    int            c;
    logic [DW-1:0] d;
    bit            last;
  } rs_t;

  wr_t wr_q[$];
  rs_t rs_q[$];
  int  cs_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [DW-1:0] fm[WORDS], fe[WORDS], fn[WORDS], fr[WORDS], ft[WORDS];
  logic [DW-1:0] ram[WORDS];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result RAM with one-cycle read latency
  initial forever begin
    @(posedge clk);
    if (bus.res_rd_en) bus.res_rd_data <= ram[bus.res_rd_addr];
  end

  // Monitor: every DUT output event must match the head of its queue
  initial begin
    wr_t w;
    rs_t s;
    int  c;
    forever begin
      @(negedge clk);
      if (bus.op_we) begin
        vectors++;
        if (wr_q.size() == 0) begin
          miscompares++;
          $display("FAIL op_write unexpected: addr=%0d cyc=%0d, none required", bus.op_addr, cyc);
        end else begin
          w = wr_q.pop_front();
          if (w.c !== cyc || w.a !== bus.op_addr || w.m !== bus.op_m || w.e !== bus.op_e ||
              w.n !== bus.op_n || w.r !== bus.op_r || w.t !== bus.op_t || w.ld !== bus.load_done) begin
            miscompares++;
            $display("FAIL op_write: got cyc=%0d addr=%0d m=%h e=%h ld=%0d, expected cyc=%0d addr=%0d m=%h e=%h ld=%0d",
                     cyc, bus.op_addr, bus.op_m, bus.op_e, bus.load_done, w.c, w.a, w.m, w.e, w.ld);
          end
        end
      end else if (bus.load_done) begin
        vectors++;
        miscompares++;
        $display("FAIL load_done: got 1 without op_we at cyc=%0d, expected 0", cyc);
      end

      if (bus.res_valid) begin
        vectors++;
        if (rs_q.size() == 0) begin
          miscompares++;
          $display("FAIL res_word unexpected: data=%h cyc=%0d, none required", bus.res_out, cyc);
        end else begin
          s = rs_q.pop_front();
          if (s.c !== cyc || s.d !== bus.res_out || s.last !== bus.res_last) begin
            miscompares++;
            $display("FAIL res_word: got cyc=%0d data=%h last=%0d, expected cyc=%0d data=%h last=%0d",
                     cyc, bus.res_out, bus.res_last, s.c, s.d, s.last);
          end
        end
      end else if (bus.res_last) begin
        vectors++;
        miscompares++;
        $display("FAIL res_last: got 1 without res_valid at cyc=%0d, expected 0", cyc);
      end

      if (bus.core_start) begin
        vectors++;
        if (cs_q.size() == 0) begin
          miscompares++;
          $display("FAIL core_start unexpected: cyc=%0d, none required", cyc);
        end else begin
          c = cs_q.pop_front();
          if (c != cyc) begin
            miscompares++;
            $display("FAIL core_start: got cyc=%0d, expected cyc=%0d", cyc, c);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.start_input   = 1'b0;
    bus.in_valid      = 1'b0;
    bus.m_in          = '0;
    bus.e_in          = '0;
    bus.n_in          = '0;
    bus.r_in          = '0;
    bus.t_in          = '0;
    bus.nprime0_in    = '0;
    bus.start_compute = 1'b0;
    bus.core_done     = 1'b0;
    bus.get_result    = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < WORDS; k++) begin
      fm[k] = rnd(); fe[k] = rnd(); fn[k] = rnd(); fr[k] = rnd(); ft[k] = rnd();
    end
  endtask

  task automatic do_start(input logic [63:0] np, input bit with_word);
    bus.start_input = 1'b1;
    bus.nprime0_in  = np;
    if (with_word) begin
      bus.in_valid = 1'b1;
      bus.m_in     = rnd();
    end
    tick();
    bus.start_input = 1'b0;
    bus.in_valid    = 1'b0;
    chk("nprime0_captured", bus.nprime0, np);
    chk("state_load", 64'(bus.state), 64'd1);
  endtask

  // gap_mode: 0 back-to-back, 1 alternate cycles, 2 random gaps
  task automatic load_frame(input int gap_mode, input int abort_at, input int bad_start_at);
    logic [DW-1:0] ck;
    wr_t w;
    int g;
    ck = '0;
    for (int k = 0; k < WORDS; k++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? ((k > 0) ? 1 : 0) : int'($urandom_range(0, 2));
      repeat (g) tick();
      bus.in_valid = 1'b1;
      bus.m_in = fm[k]; bus.e_in = fe[k]; bus.n_in = fn[k]; bus.r_in = fr[k]; bus.t_in = ft[k];
      if (k == abort_at) begin
        reset = 1'b1;
        tick();
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_op_we", 64'(bus.op_we), 64'd0);
        chk("rst_nprime0", bus.nprime0, 64'd0);
        chk("rst_err", 64'(bus.err_proto), 64'd0);
        reset = 1'b0;
        bus.in_valid = 1'b0;
        return;
      end
      if (k == bad_start_at) begin
        bus.start_input = 1'b1;
        bus.nprime0_in  = rnd();
      end
      w.c = cyc + 1; w.a = AW'(k);
      w.m = fm[k]; w.e = fe[k]; w.n = fn[k]; w.r = fr[k]; w.t = ft[k];
      w.ld = (k == WORDS - 1);
      wr_q.push_back(w);
      ck = ck ^ fm[k] ^ fe[k] ^ fn[k] ^ fr[k] ^ ft[k];
      tick();
      bus.in_valid    = 1'b0;
      bus.start_input = 1'b0;
    end
`ifdef MODEXP_IO_CKSUM_EN
    chk("load_cksum", bus.load_cksum, ck);
`endif
    tick();
    chk("state_loaded", 64'(bus.state), 64'd2);
  endtask

  task automatic compute_unload(input bit get_early);
    rs_t s;
    int n;
    bus.start_compute = 1'b1;
    cs_q.push_back(cyc + 1);
    tick();
    bus.start_compute = 1'b0;
    chk("state_compute", 64'(bus.state), 64'd3);
    chk("busy_compute", 64'(bus.busy), 64'd1);
    if (get_early) begin
      bus.get_result = 1'b1;
      tick();
      bus.get_result = 1'b0;
      chk("get_in_compute_state", 64'(bus.state), 64'd3);
      chk("get_in_compute_err", 64'(bus.err_proto), 64'd1);
    end
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("state_ready", 64'(bus.state), 64'd4);
    chk("busy_ready", 64'(bus.busy), 64'd0);
    n = cyc;
    for (int k = 0; k < WORDS; k++) begin
      s.c = n + 3 + k; s.d = ram[k]; s.last = (k == WORDS - 1);
      rs_q.push_back(s);
    end
    bus.get_result = 1'b1;
    tick();
    bus.get_result = 1'b0;
    chk("state_unload", 64'(bus.state), 64'd5);
    repeat (WORDS + 2) tick();
    chk("state_idle_after_unload", 64'(bus.state), 64'd0);
    chk("results_outstanding", 64'(rs_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] np;
    idle_inputs();
    bus.res_rd_data = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_state", 64'(bus.state), 64'd0);
    chk("reset_op_we", 64'(bus.op_we), 64'd0);
    chk("reset_nprime0", bus.nprime0, 64'd0);
    chk("reset_err", 64'(bus.err_proto), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_res_valid", 64'(bus.res_valid), 64'd0);
    reset = 1'b0;
    tick();

    // Protocol violations in IDLE
    bus.in_valid = 1'b1; bus.m_in = rnd();
    tick();
    bus.in_valid = 1'b0;
    chk("in_valid_idle_err", 64'(bus.err_proto), 64'd1);
    chk("in_valid_idle_state", 64'(bus.state), 64'd0);
    bus.start_compute = 1'b1;
    tick();
    bus.start_compute = 1'b0;
    chk("start_compute_idle_state", 64'(bus.state), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", 64'(bus.err_proto), 64'd0);

    // Frame A: m=8, e=13, n=77 in word 0, back-to-back
    for (int k = 0; k < WORDS; k++) begin
      fm[k] = '0; fe[k] = '0; fn[k] = '0; fr[k] = '0; ft[k] = '0;
      ram[k] = DW'(k + 1);
    end
    fm[0] = 64'd8; fe[0] = 64'd13; fn[0] = 64'd77;
    do_start(64'h0123_4567_89ab_cdef, 1'b0);
    load_frame(0, -1, -1);
    chk("frameA_err", 64'(bus.err_proto), 64'd0);
    compute_unload(1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Frame B: alternate-cycle in_valid, random data and result RAM
    fill_random();
    do_start(rnd(), 1'b0);
    load_frame(1, -1, -1);
    chk("frameB_err", 64'(bus.err_proto), 64'd0);
    for (int k = 0; k < WORDS; k++) ram[k] = rnd();
    compute_unload(1'b0);

    // Frame C: random gaps with a rejected start_input mid-load
    fill_random();
    np = rnd();
    do_start(np, 1'b0);
    load_frame(2, -1, 10);
    chk("frameC_err", 64'(bus.err_proto), 64'd1);
    chk("frameC_nprime0_kept", bus.nprime0, np);

    // Frame D: aborted by reset at word 30
    fill_random();
    do_start(rnd(), 1'b0);
    load_frame(0, 30, -1);

    // Frame E: start with a simultaneous word (discarded), fresh load from address 0
`ifdef MODEXP_IO_CKSUM_EN
    for (int k = 0; k < WORDS; k++) begin
      fm[k] = DW'(k); fe[k] = '0; fn[k] = '0; fr[k] = '0; ft[k] = '0;
    end
`else
    fill_random();
`endif
    do_start(rnd(), 1'b1);
    chk("start_with_word_err", 64'(bus.err_proto), 64'd0);
    load_frame(2, -1, -1);
    chk("frameE_err", 64'(bus.err_proto), 64'd0);
    for (int k = 0; k < WORDS; k++) ram[k] = rnd();
    compute_unload(1'b0);

    tick();
    chk("writes_outstanding", 64'(wr_q.size()), 64'd0);
    chk("core_start_outstanding", 64'(cs_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/modexp_io_port.md
# modexp_io_port

Word-serial host interface for the ModExp core: the responder end of the operand/result streaming protocol. The host streams operand words (m, e, n, r, t) and the nprime0 constant into it. It converts the stream into addressed writes to the core's operand RAMs, starts the core, waits for completion, then reads the result RAM and streams the result words back to the host. It sits between the host-side sequencer and the ModExp datapath.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result word width
- WORDS, 64, words per 4096-bit operand
- AW, 6, word address width; must satisfy 2^AW >= WORDS

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start_input  in  1  pulse; opens a load frame and captures nprime0_in
- in_valid  in  1  qualifies one operand word set on the m/e/n/r/t inputs
- m_in, e_in, n_in, r_in, t_in  in  DATA_WIDTH each  operand words, least-significant word first
- nprime0_in  in  64  Montgomery constant
- op_we  out  1  operand RAM write strobe
- op_addr  out  AW  operand word address
- op_m, op_e, op_n, op_r, op_t  out  DATA_WIDTH each  registered write data
- nprime0  out  64  held constant for the core
- load_done  out  1  one-cycle pulse
- start_compute  in  1  host request to start the core
- core_start  out  1  one-cycle pulse to the core
- core_done  in  1  core completion pulse
- get_result  in  1  host request to stream the result out
- res_rd_en  out  1  result RAM read strobe
- res_rd_addr  out  AW  result RAM address
- res_rd_data  in  DATA_WIDTH  result RAM data, 1-cycle read latency
- res_out  out  DATA_WIDTH  result word
- res_valid  out  1  qualifies res_out
- res_last  out  1  high with the final result word
- busy  out  1  high in LOAD, COMPUTE or UNLOAD
- state  out  3  current FSM state
- err_proto  out  1  sticky protocol-violation flag

## Operation
- States: IDLE=0, LOAD=1, LOADED=2, COMPUTE=3, READY=4, UNLOAD=5.
- start_input:
  - Accepted in IDLE, LOADED or READY.
  - On acceptance: go to LOAD, clear the word counter and capture nprime0_in into nprime0.
- LOAD:
  - Each in_valid cycle registers the five inputs onto op_* with op_addr=counter and op_we=1 in the next cycle, then increments the counter.
  - The word with counter=WORDS-1 also asserts load_done in the same cycle as its op_we. The FSM moves to LOADED and the counter wraps to 0.
  - Gaps (in_valid=0) are allowed without limit.
- LOADED:
  - start_compute produces core_start for one cycle, then the FSM moves to COMPUTE.
- COMPUTE:
  - core_done moves the FSM to READY.
- READY:
  - get_result moves the FSM to UNLOAD.
  - res_rd_en=1 for WORDS consecutive cycles, with addresses 0..WORDS-1.
  - res_rd_data is registered into res_out with res_valid=1. The final word also asserts res_last.
  - The cycle after res_last, the FSM returns to IDLE.
- Protocol violations set err_proto; the offending input is ignored and the state is unchanged:
  - in_valid outside LOAD.
  - start_input in LOAD, COMPUTE or UNLOAD.
  - start_compute outside LOADED.
  - get_result outside READY.
  - core_done outside COMPUTE.
- Simultaneous events:
  - start_input and in_valid in the same accepting cycle: start wins. The word is discarded and no error is raised.
  - In LOAD, in_valid and a rejected start_input in the same cycle: the word is written and err_proto is set.
- Reset (also mid-operation):
  - state=IDLE.
  - All outputs 0, including nprime0, err_proto and the counter.
  - An in-progress frame is abandoned; RAM contents are undefined to the core.

## Timing
- Load: in_valid in cycle c gives op_we/op_addr/op_* in cycle c+1.
  - Back-to-back frame of WORDS words starting at cycle c: load_done in cycle c+WORDS, state=LOADED in c+WORDS+1.
- core_start is high in the cycle after start_compute is sampled.
- Unload: get_result sampled in cycle n gives:
  - res_rd_en in cycles n+1..n+WORDS.
  - res_valid in cycles n+3..n+WORDS+2.
  - res_last in n+WORDS+2.
  - state=IDLE in n+WORDS+3.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- MODEXP_IO_CKSUM_EN:
  - When defined, an extra output load_cksum [DATA_WIDTH-1:0] holds the XOR of all m, e, n, r, t words written in the current frame.
  - The value is cleared on reset and on an accepted start_input. It is valid from the load_done cycle until the next frame starts.
- Without the macro, the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Load frame with message=8, exponent=13, modulus=77 (all other words 0), WORDS back-to-back in_valid:
  - 64 op_we cycles, addresses 0..63; op_m=8 at addr 0 only.
  - load_done one cycle after the last in_valid.
- Load with in_valid toggling every other cycle: addresses stay contiguous, load_done after word 63, no err_proto.
- Full flow with a result RAM model holding word k = k+1:
  - start_compute → core_start one cycle later.
  - Inject core_done → READY.
  - get_result → res_out 1..64 with res_valid, res_last on 64, IDLE afterwards.
- Violations:
  - in_valid in IDLE → err_proto=1, no op_we.
  - start_compute in IDLE → no core_start.
  - get_result in COMPUTE → ignored.
- Reset asserted at word 30 of a load: next cycle state=0, op_we=0, nprime0=0, err_proto=0. A fresh frame then loads from address 0.
- With MODEXP_IO_CKSUM_EN defined: frame with m_in=k and e/n/r/t=0 for word k → load_cksum=0 at load_done, since the XOR of 0..63 is 0.
